// File: rtl/dspb_serum_oci_trace_pkg.sv
// Shared types and default widths for the OCI trace-capture sink.
package dspb_serum_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam int DEF_BUF_W   = 30;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TOTAL_W = 32;
  localparam int DEF_DROP_W  = 16;

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit above the pointer.
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dspb_serum_oci_trace_fifo.sv
// First-word-fall-through FIFO; the head entry is presented on data while
// non-empty, and a push into a full FIFO is accepted when a pop coincides.
module dspb_serum_oci_trace_fifo
  import dspb_serum_oci_trace_pkg::*;
#(
  parameter int DATA_W = DEF_CNT_W + DEF_BUF_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int LVL_W = fifo_lvl_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset: emptiness is defined solely by level_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign data  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/dspb_serum_nios2_oci_trace_capture.sv
// Trace-capture sink: qualifies DCT words into a FWFT FIFO, keeps frame/drop
// statistics and sequences end-of-test into a drain-then-done indication.
module dspb_serum_nios2_oci_trace_capture
  import dspb_serum_oci_trace_pkg::*;
#(
  parameter int BUF_W   = DEF_BUF_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TOTAL_W = DEF_TOTAL_W,
  parameter int DROP_W  = DEF_DROP_W,
  localparam int LVL_W  = fifo_lvl_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BUF_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   dct_valid,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  output logic [CNT_W+BUF_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LVL_W-1:0]       fifo_level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [TOTAL_W-1:0]     frame_total,
  output logic [1:0]             state_o,
  output logic                   done
);

  trace_state_e          state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic [TOTAL_W-1:0]    total_q, total_d;

  logic                  candidate;
  logic                  want_push;
  logic                  accept;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Zero-count words carry no frames and are invisible in every state.
  assign candidate = dct_valid && (dct_count != '0);
  assign pop       = out_valid && out_ready;

  // test_has_ended outranks capture, so a same-cycle word is discarded.
  assign want_push = candidate && !test_has_ended &&
                     ((state_q == ST_IDLE) || (state_q == ST_CAPTURE));
  assign accept    = want_push && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (test_has_ended)   state_d = ST_DONE;
        else if (test_ending) state_d = ST_DRAIN;
        else if (candidate)   state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (test_has_ended)   state_d = ST_DONE;
        else if (test_ending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty || test_has_ended) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    total_d    = total_q;
    if (accept) begin
      total_d = total_q + TOTAL_W'(dct_count);
    end else if (want_push) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      total_q    <= total_d;
    end
  end

  dspb_serum_oci_trace_fifo #(
    .DATA_W (CNT_W + BUF_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data ({dct_count, dct_buffer}),
    .pop       (pop),
    .data      (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign out_valid   = !fifo_empty;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign frame_total = total_q;
  assign state_o     = state_q;
  assign done        = (state_q == ST_DONE) && fifo_empty;

endmodule
